ifetch_uc_axi: RTL and testbench

IFETCH_UC_AXI -- requirements
Module: ifetch_uc_axi

---
 rtl/ifetch_uc_axi.sv | 124 ++++++++++++
 tb/tb_ifetch_uc_axi.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_uc_axi.sv
// Uncached single-beat AXI4 instruction fetch unit: one outstanding read,
// one 32-bit word per request, with flush handling that keeps the AR/R handshakes legal.
module ifetch_uc_axi #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        inst_err_o,
  output logic        stall_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        err_q;
  logic        flush_pend_q;
  logic        beat_ok;

  // Single-beat bursts make every beat the last one, so rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign araddr  = addr_q;

  // Beats tagged with another ID are still taken (rready is high) but never acted on.
  assign beat_ok = rvalid && (rid == AXI_ID);

  assign inst_valid_o = (state == S_DONE) && !flush_i;
  assign inst_err_o   = inst_valid_o && err_q;
  assign stall_o      = ((state == S_IDLE) && req_i) || (state == S_ADDR) ||
                        (state == S_DATA) || (state == S_DRAIN);

  // NOTE: all state uses non-blocking assignments and the asynchronous reset, so a
  // reset mid-transaction drops everything immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= 32'd0;
      inst_o       <= 32'd0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i && !flush_i) begin
            addr_q  <= {req_addr_i[31:2], 2'b00};
            arvalid <= 1'b1;
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          // The address must stay presented until accepted; a flush only redirects the result.
          if (flush_i) flush_pend_q <= 1'b1;
          if (arready) begin
            arvalid      <= 1'b0;
            rready       <= 1'b1;
            flush_pend_q <= 1'b0;
            state        <= (flush_pend_q || flush_i) ? S_DRAIN : S_DATA;
          end
        end
        S_DATA: begin
          if (beat_ok) begin
            rready <= 1'b0;
            if (flush_i) begin
              state <= S_IDLE;
            end else begin
              inst_o <= rdata;
              err_q  <= (rresp != 2'b00);
              state  <= S_DONE;
            end
          end else if (flush_i) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (beat_ok) begin
            rready <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          arvalid <= 1'b0;
          rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_uc_axi.sv
// Bench for ifetch_uc_axi: the bench plays the AXI slave, runs directed vectors plus
// random transactions, and predicts outcomes from a transaction-level model.
module tb_ifetch_uc_axi;

  localparam logic [3:0] TB_ID = 4'd5;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_err_o;
  logic        stall_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  ifetch_uc_axi #(.AXI_ID(TB_ID)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_addr_i(req_addr_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_err_o(inst_err_o), .stall_o(stall_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 plain, 1 flush in ADDR, 2 flush in DATA before the beat,
  //       3 flush together with the beat, 4 flush during the result cycle
  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    int          r_delay;
    int          nbad;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          mode;
    logic [31:0] exp_araddr;
    bit          exp_pulse;
    bit          exp_capture;
  } vec_t;

  int          total;
  int          bad;
  logic [31:0] model_inst;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input int ard, input int rd, input int nb,
                              input logic [31:0] data, input logic [1:0] resp, input int mode,
                              input logic [31:0] exp_ad, input bit pulse, input bit capture);
    vec_t v;
    v.addr = addr; v.ar_delay = ard; v.r_delay = rd; v.nbad = nb;
    v.rdata = data; v.rresp = resp; v.mode = mode;
    v.exp_araddr = exp_ad; v.exp_pulse = pulse; v.exp_capture = capture;
    return v;
  endfunction

  // Transaction-level expectations: word-aligned address, pulse only when never flushed,
  // capture whenever the beat arrived before any flush.
  function automatic vec_t rand_vec();
    vec_t v;
    v.addr     = $urandom;
    v.ar_delay = $urandom_range(0, 3);
    v.r_delay  = $urandom_range(0, 3);
    v.nbad     = $urandom_range(0, 2);
    v.rdata    = $urandom;
    v.rresp    = 2'($urandom_range(0, 3));
    v.mode     = $urandom_range(0, 4);
    if (v.mode == 2 && v.nbad + v.r_delay == 0) v.r_delay = 1;
    v.exp_araddr  = v.addr & 32'hFFFF_FFFC;
    v.exp_pulse   = (v.mode == 0);
    v.exp_capture = (v.mode == 0) || (v.mode == 4);
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int n_r;
    bit good;
    req_i = 1'b1; req_addr_i = v.addr; flush_i = 1'b0; arready = 1'b0; rvalid = 1'b0;
    #1;
    check1("stall_req", stall_o, 1'b1);
    check1("arvalid_idle", arvalid, 1'b0);
    check1("valid_req", inst_valid_o, 1'b0);
    step();
    for (int k = 0; k <= v.ar_delay; k++) begin
      req_i   = 1'($urandom_range(0, 1));
      arready = (k == v.ar_delay);
      flush_i = (v.mode == 1) && (k == 0);
      #1;
      check1("arvalid_addr", arvalid, 1'b1);
      check("araddr", araddr, v.exp_araddr);
      check1("rready_addr", rready, 1'b0);
      check1("stall_addr", stall_o, 1'b1);
      check1("valid_addr", inst_valid_o, 1'b0);
      step();
    end
    arready = 1'b0; flush_i = 1'b0; req_i = 1'b0;
    n_r = v.nbad + v.r_delay + 1;
    for (int k = 0; k < n_r; k++) begin
      good = (k == n_r - 1);
      if (k < v.nbad) begin
        rvalid = 1'b1; rid = TB_ID + 4'd1; rdata = $urandom; rresp = 2'b00;
      end else if (!good) begin
        rvalid = 1'b0; rid = TB_ID; rdata = $urandom; rresp = 2'b00;
      end else begin
        rvalid = 1'b1; rid = TB_ID; rdata = v.rdata; rresp = v.rresp;
      end
      flush_i = ((v.mode == 2) && (k == 0)) || ((v.mode == 3) && good);
      #1;
      check1("rready_data", rready, 1'b1);
      check1("arvalid_data", arvalid, 1'b0);
      check1("stall_data", stall_o, 1'b1);
      check1("valid_data", inst_valid_o, 1'b0);
      check("inst_hold_data", inst_o, model_inst);
      step();
    end
    rvalid = 1'b0; flush_i = 1'b0;
    if (v.exp_capture) model_inst = v.rdata;
    if (v.mode == 0 || v.mode == 4) begin
      req_i   = 1'($urandom_range(0, 1));
      flush_i = (v.mode == 4);
      #1;
      check1("valid_done", inst_valid_o, v.exp_pulse);
      check1("err_done", inst_err_o, v.exp_pulse && (v.rresp != 2'b00));
      check("inst_done", inst_o, model_inst);
      check1("stall_done", stall_o, 1'b0);
      check1("arvalid_done", arvalid, 1'b0);
      check1("rready_done", rready, 1'b0);
      step();
      req_i = 1'b0; flush_i = 1'b0;
    end
    #1;
    check1("valid_after", inst_valid_o, 1'b0);
    check1("stall_after", stall_o, 1'b0);
    check1("arvalid_after", arvalid, 1'b0);
    check1("rready_after", rready, 1'b0);
    check("inst_after", inst_o, model_inst);
    step();
  endtask

  initial begin
    total = 0; bad = 0; model_inst = 32'd0;
    rst_n = 1'b0; req_i = 1'b0; req_addr_i = 32'd0; flush_i = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;

    vecs[0] = mk(32'hBFC0_0000, 0, 0, 0, 32'h3C1D_BFC0, 2'b00, 0, 32'hBFC0_0000, 1, 1);
    vecs[1] = mk(32'h0000_1000, 4, 0, 0, 32'h1234_5678, 2'b00, 0, 32'h0000_1000, 1, 1);
    vecs[2] = mk(32'h0000_2000, 1, 2, 0, 32'hDEAD_BEEF, 2'b00, 1, 32'h0000_2000, 0, 0);
    vecs[3] = mk(32'h0000_3000, 0, 0, 0, 32'h0000_0000, 2'b10, 0, 32'h0000_3000, 1, 1);
    vecs[4] = mk(32'hBFC0_0006, 0, 1, 1, 32'hCAFE_F00D, 2'b00, 0, 32'hBFC0_0004, 1, 1);
    vecs[5] = mk(32'h0000_0004, 2, 3, 0, 32'h1111_1111, 2'b00, 2, 32'h0000_0004, 0, 0);
    vecs[6] = mk(32'h0000_0008, 0, 0, 1, 32'h2222_2222, 2'b01, 3, 32'h0000_0008, 0, 0);
    vecs[7] = mk(32'h0000_000F, 0, 0, 0, 32'h3333_3333, 2'b11, 4, 32'h0000_000C, 0, 1);
    vecs[8] = mk(32'h0000_0010, 0, 0, 0, 32'h4444_4444, 2'b00, 1, 32'h0000_0010, 0, 0);

    #1;
    check1("rst_arvalid", arvalid, 1'b0);
    check1("rst_rready", rready, 1'b0);
    check("rst_inst", inst_o, 32'd0);
    check1("rst_valid", inst_valid_o, 1'b0);
    check1("rst_err", inst_err_o, 1'b0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_consts", {arid, arlen, arsize, arburst}, {4'd5, 8'd0, 3'b010, 2'b01});
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    // A flush in IDLE blocks the request for that cycle.
    req_i = 1'b1; req_addr_i = 32'h0000_0100; flush_i = 1'b1;
    #1 check1("idle_flush_stall", stall_o, 1'b1);
    step();
    req_i = 1'b0; flush_i = 1'b0;
    #1 check1("idle_flush_blocked", arvalid, 1'b0);
    step();

    // Reset during DATA, then a late beat after release.
    req_i = 1'b1; req_addr_i = 32'h0000_0200;
    step();
    req_i = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    #1 check1("pre_rst_rready", rready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check1("mid_rst_rready", rready, 1'b0);
    check1("mid_rst_arvalid", arvalid, 1'b0);
    check1("mid_rst_stall", stall_o, 1'b0);
    check("mid_rst_inst", inst_o, 32'd0);
    model_inst = 32'd0;
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; rid = TB_ID; rdata = 32'hAAAA_5555; rresp = 2'b10;
    #1 check1("late_beat_rready", rready, 1'b0);
    step();
    rvalid = 1'b0;
    #1;
    check1("late_beat_valid", inst_valid_o, 1'b0);
    check1("late_beat_err", inst_err_o, 1'b0);
    check1("late_beat_stall", stall_o, 1'b0);
    check("late_beat_inst", inst_o, 32'd0);
    step();

    for (int i = 0; i < 40; i++) run_txn(rand_vec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
